// File: rtl/iopmp_err_pkg.sv
// Shared types for the IOPMP error responder: AXI channel structs (ID width 4),
// FSM state encodings and the atomic-read slot handed from the write side to the read side.
package iopmp_err_pkg;

    typedef logic [3:0]  id_t;
    typedef logic [7:0]  len_t;
    typedef logic [63:0] addr_t;
    typedef logic [63:0] data_t;
    typedef logic [7:0]  strb_t;
    typedef logic [1:0]  resp_code_t;

    localparam resp_code_t RESP_SLVERR    = 2'b10;
    localparam data_t      RESP_DATA_DFLT = 64'hBADC_AB1E_DEAD_BEEF;

    typedef struct packed {
        id_t        id;
        addr_t      addr;
        len_t       len;
        logic [2:0] size;
        logic [1:0] burst;
        logic [5:0] atop;
    } aw_chan_t;

    typedef struct packed {
        data_t data;
        strb_t strb;
        logic  last;
    } w_chan_t;

    typedef struct packed {
        id_t        id;
        resp_code_t resp;
        logic       user;
    } b_chan_t;

    typedef struct packed {
        id_t        id;
        addr_t      addr;
        len_t       len;
        logic [2:0] size;
        logic [1:0] burst;
    } ar_chan_t;

    typedef struct packed {
        id_t        id;
        data_t      data;
        resp_code_t resp;
        logic       last;
        logic       user;
    } r_chan_t;

    typedef struct packed {
        aw_chan_t aw;
        logic     aw_valid;
        w_chan_t  w;
        logic     w_valid;
        logic     b_ready;
        ar_chan_t ar;
        logic     ar_valid;
        logic     r_ready;
    } axi_req_t;

    typedef struct packed {
        logic    aw_ready;
        logic    ar_ready;
        logic    w_ready;
        logic    b_valid;
        b_chan_t b;
        logic    r_valid;
        r_chan_t r;
    } axi_rsp_t;

    typedef struct packed {
        id_t  id;
        len_t len;
    } atop_slot_t;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } w_state_e;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } r_state_e;

endpackage

// File: rtl/iopmp_err_rd_chan.sv
// Read side of the error responder: R burst generation and completed-read counter.
// state  | meaning
// R_IDLE | waiting for AR or a pending atomic read response
// R_DATA | streaming error beats, last when beat counter reaches 0
module iopmp_err_rd_chan
    import iopmp_err_pkg::*;
#(
    parameter int unsigned CntWidth = 16
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                ar_valid,
    input  id_t                 ar_id,
    input  len_t                ar_len,
    output logic                ar_ready,
    input  logic                atop_pend,
    input  atop_slot_t          atop_slot,
    output logic                atop_take,
    output logic                r_valid,
    input  logic                r_ready,
    output id_t                 r_id,
    output logic                r_last,
    input  logic                cnt_clr,
    output logic [CntWidth-1:0] err_rd_cnt,
    output logic                idle
);

    localparam logic [CntWidth-1:0] CntOne = CntWidth'(1);

    r_state_e            state_q, state_d;
    id_t                 id_q;
    len_t                beat_q;
    logic [CntWidth-1:0] cnt_q;
    logic                ar_hs;
    logic                r_hs;

    assign ar_hs = ar_valid && ar_ready;
    assign r_hs  = r_valid && r_ready;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= R_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            R_IDLE: begin
                if (atop_take || ar_hs) begin
                    state_d = R_DATA;
                end
            end
            R_DATA: begin
                if (r_hs && r_last) begin
                    state_d = R_IDLE;
                end
            end
            default: state_d = R_IDLE;
        endcase
    end

    // A pending atomic read response wins over a new AR by holding ar_ready low.
    always_comb begin
        ar_ready  = (state_q == R_IDLE) && !atop_pend;
        atop_take = (state_q == R_IDLE) && atop_pend;
        r_valid   = (state_q == R_DATA);
        r_last    = (state_q == R_DATA) && (beat_q == '0);
        r_id      = (state_q == R_DATA) ? id_q : '0;
        idle      = (state_q == R_IDLE);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            id_q   <= '0;
            beat_q <= '0;
        end else if (atop_take) begin
            id_q   <= atop_slot.id;
            beat_q <= atop_slot.len;
        end else if (ar_hs) begin
            id_q   <= ar_id;
            beat_q <= ar_len;
        end else if (r_hs && (beat_q != '0)) begin
            beat_q <= beat_q - len_t'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || cnt_clr) begin
            cnt_q <= '0;
        end else if (r_hs && r_last && (cnt_q != '1)) begin
            cnt_q <= cnt_q + CntOne;
        end
    end

    assign err_rd_cnt = cnt_q;

endmodule

// File: rtl/iopmp_err_responder.sv
// Terminal AXI4 slave for IOPMP-denied traffic: completes every burst with an error response.
// state  | meaning
// W_IDLE | waiting for AW (blocked while an atomic read response is pending)
// W_DATA | absorbing W beats until w.last
// W_RESP | presenting B
module iopmp_err_responder
    import iopmp_err_pkg::*;
#(
    parameter type         req_t    = axi_req_t,
    parameter type         resp_t   = axi_rsp_t,
    parameter resp_code_t  RespCode = RESP_SLVERR,
    parameter data_t       RespData = RESP_DATA_DFLT,
    parameter int unsigned CntWidth = 16
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  req_t                slv_req_i,
    output resp_t               slv_rsp_o,
    input  logic                cnt_clr_i,
    output logic [CntWidth-1:0] err_wr_cnt_o,
    output logic [CntWidth-1:0] err_rd_cnt_o,
    output logic                busy_o
);

    localparam logic [CntWidth-1:0] CntOne = CntWidth'(1);

    w_state_e            w_state_q, w_state_d;
    id_t                 w_id_q;
    logic                w_atop_q;
    atop_slot_t          atop_slot_q;
    logic                atop_pend_q;
    logic [CntWidth-1:0] wr_cnt_q;

    logic aw_ready, w_ready, b_valid;
    logic aw_hs, w_hs, b_hs;

    logic                ar_ready, atop_take;
    logic                r_valid, r_last;
    id_t                 r_id;
    logic [CntWidth-1:0] rd_cnt;
    logic                rd_idle;

    resp_t rsp_d;
    logic  unused_req;

    assign aw_hs = slv_req_i.aw_valid && aw_ready;
    assign w_hs  = slv_req_i.w_valid && w_ready;
    assign b_hs  = b_valid && slv_req_i.b_ready;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            w_state_q <= W_IDLE;
        end else begin
            w_state_q <= w_state_d;
        end
    end

    // AW.len is deliberately ignored for the data phase; only w.last ends it.
    always_comb begin
        w_state_d = w_state_q;
        case (w_state_q)
            W_IDLE: if (aw_hs) w_state_d = W_DATA;
            W_DATA: if (w_hs && slv_req_i.w.last) w_state_d = W_RESP;
            W_RESP: if (b_hs) w_state_d = W_IDLE;
            default: w_state_d = W_IDLE;
        endcase
    end

    always_comb begin
        aw_ready = (w_state_q == W_IDLE) && !atop_pend_q;
        w_ready  = (w_state_q == W_DATA);
        b_valid  = (w_state_q == W_RESP);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            w_id_q      <= '0;
            w_atop_q    <= 1'b0;
            atop_slot_q <= '0;
        end else if (aw_hs) begin
            w_id_q   <= slv_req_i.aw.id;
            w_atop_q <= slv_req_i.aw.atop[5];
            if (slv_req_i.aw.atop[5]) begin
                atop_slot_q.id  <= slv_req_i.aw.id;
                atop_slot_q.len <= slv_req_i.aw.len;
            end
        end
    end

    // Atomics with a read result owe an R burst once B has been accepted.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            atop_pend_q <= 1'b0;
        end else if (b_hs && w_atop_q) begin
            atop_pend_q <= 1'b1;
        end else if (atop_take) begin
            atop_pend_q <= 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || cnt_clr_i) begin
            wr_cnt_q <= '0;
        end else if (b_hs && (wr_cnt_q != '1)) begin
            wr_cnt_q <= wr_cnt_q + CntOne;
        end
    end

    iopmp_err_rd_chan #(
        .CntWidth (CntWidth)
    ) u_rd_chan (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .ar_valid   (slv_req_i.ar_valid),
        .ar_id      (slv_req_i.ar.id),
        .ar_len     (slv_req_i.ar.len),
        .ar_ready   (ar_ready),
        .atop_pend  (atop_pend_q),
        .atop_slot  (atop_slot_q),
        .atop_take  (atop_take),
        .r_valid    (r_valid),
        .r_ready    (slv_req_i.r_ready),
        .r_id       (r_id),
        .r_last     (r_last),
        .cnt_clr    (cnt_clr_i),
        .err_rd_cnt (rd_cnt),
        .idle       (rd_idle)
    );

    // Everything visible is forced to zero while reset is held.
    always_comb begin
        rsp_d = '0;
        if (!rst_i) begin
            rsp_d.aw_ready = aw_ready;
            rsp_d.w_ready  = w_ready;
            rsp_d.b_valid  = b_valid;
            rsp_d.b.id     = b_valid ? w_id_q : '0;
            rsp_d.b.resp   = b_valid ? RespCode : '0;
            rsp_d.b.user   = 1'b0;
            rsp_d.ar_ready = ar_ready;
            rsp_d.r_valid  = r_valid;
            rsp_d.r.id     = r_id;
            rsp_d.r.data   = r_valid ? RespData : '0;
            rsp_d.r.resp   = r_valid ? RespCode : '0;
            rsp_d.r.last   = r_last;
            rsp_d.r.user   = 1'b0;
        end
    end

    assign slv_rsp_o    = rsp_d;
    assign err_wr_cnt_o = rst_i ? '0 : wr_cnt_q;
    assign err_rd_cnt_o = rst_i ? '0 : rd_cnt;
    assign busy_o       = !rst_i && ((w_state_q != W_IDLE) || !rd_idle || atop_pend_q);

    assign unused_req = ^{slv_req_i.aw.addr, slv_req_i.aw.size, slv_req_i.aw.burst,
                          slv_req_i.aw.atop[4:0], slv_req_i.w.data, slv_req_i.w.strb,
                          slv_req_i.ar.addr, slv_req_i.ar.size, slv_req_i.ar.burst};

endmodule

// File: tb/tb_iopmp_err_responder.sv
// Scoreboard bench for the IOPMP error responder; a narrow-counter instance covers saturation.
module tb_iopmp_err_responder;
    import iopmp_err_pkg::*;

    typedef struct {
        id_t  id;
        logic last;
    } r_exp_t;

    logic        clk_sys = 1'b0;
    logic        rst;
    axi_req_t    req;
    axi_rsp_t    rsp;
    logic        cnt_clr;
    logic [15:0] wr_cnt, rd_cnt;
    logic        busy;

    axi_req_t    req_s;
    axi_rsp_t    rsp_s;
    logic        cnt_clr_s;
    logic [1:0]  wr_cnt_s, rd_cnt_s;
    logic        busy_s;

    id_t    b_q[$];
    r_exp_t r_q[$];
    int     n_total = 0;
    int     n_bad   = 0;
    logic   r_stall = 1'b0;
    id_t    mon_b;
    r_exp_t mon_r;

    always #5 clk_sys = ~clk_sys;

    iopmp_err_responder dut (
        .clk_i        (clk_sys),
        .rst_i        (rst),
        .slv_req_i    (req),
        .slv_rsp_o    (rsp),
        .cnt_clr_i    (cnt_clr),
        .err_wr_cnt_o (wr_cnt),
        .err_rd_cnt_o (rd_cnt),
        .busy_o       (busy)
    );

    iopmp_err_responder #(.CntWidth(2)) dut_sat (
        .clk_i        (clk_sys),
        .rst_i        (rst),
        .slv_req_i    (req_s),
        .slv_rsp_o    (rsp_s),
        .cnt_clr_i    (cnt_clr_s),
        .err_wr_cnt_o (wr_cnt_s),
        .err_rd_cnt_o (rd_cnt_s),
        .busy_o       (busy_s)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk_sys) begin
        if (rst) begin
            r_stall = 1'b0;
        end else begin
            if (r_stall && r_q.size() > 0) begin
                chk("r_hold_valid", 64'(rsp.r_valid), 64'd1);
                chk("r_hold_id", 64'(rsp.r.id), 64'(r_q[0].id));
                chk("r_hold_last", 64'(rsp.r.last), 64'(r_q[0].last));
            end
            if (rsp.b_valid && req.b_ready) begin
                if (b_q.size() == 0) begin
                    chk("b_unexp", 64'd1, 64'd0);
                end else begin
                    mon_b = b_q.pop_front();
                    chk("b_id", 64'(rsp.b.id), 64'(mon_b));
                    chk("b_resp", 64'(rsp.b.resp), 64'd2);
                    chk("b_user", 64'(rsp.b.user), 64'd0);
                end
            end
            if (rsp.r_valid && req.r_ready) begin
                if (r_q.size() == 0) begin
                    chk("r_unexp", 64'd1, 64'd0);
                end else begin
                    mon_r = r_q.pop_front();
                    chk("r_id", 64'(rsp.r.id), 64'(mon_r.id));
                    chk("r_data", rsp.r.data, 64'hBADC_AB1E_DEAD_BEEF);
                    chk("r_resp", 64'(rsp.r.resp), 64'd2);
                    chk("r_last", 64'(rsp.r.last), 64'(mon_r.last));
                    chk("r_user", 64'(rsp.r.user), 64'd0);
                end
            end
            r_stall = rsp.r_valid && !req.r_ready;
        end
    end

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic do_aw(input id_t id, input len_t len, input logic [5:0] atop);
        int n;
        tick();
        req.aw      = '0;
        req.aw.id   = id;
        req.aw.len  = len;
        req.aw.atop = atop;
        req.aw_valid = 1'b1;
        n = 0;
        @(negedge clk_sys);
        while (!rsp.aw_ready && n < 50) begin
            n++;
            @(negedge clk_sys);
        end
        chk("aw_tmo", 64'(rsp.aw_ready), 64'd1);
        tick();
        req.aw_valid = 1'b0;
    endtask

    task automatic do_ar(input id_t id, input len_t len);
        int n;
        tick();
        req.ar     = '0;
        req.ar.id  = id;
        req.ar.len = len;
        req.ar_valid = 1'b1;
        n = 0;
        @(negedge clk_sys);
        while (!rsp.ar_ready && n < 50) begin
            n++;
            @(negedge clk_sys);
        end
        chk("ar_tmo", 64'(rsp.ar_ready), 64'd1);
        tick();
        req.ar_valid = 1'b0;
    endtask

    task automatic do_w(input logic last);
        int n;
        tick();
        req.w.data  = 64'h1234_5678_9ABC_DEF0;
        req.w.strb  = 8'hFF;
        req.w.last  = last;
        req.w_valid = 1'b1;
        n = 0;
        @(negedge clk_sys);
        while (!rsp.w_ready && n < 50) begin
            n++;
            @(negedge clk_sys);
        end
        chk("w_tmo", 64'(rsp.w_ready), 64'd1);
        tick();
        req.w_valid = 1'b0;
        req.w.last  = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        @(negedge clk_sys);
        while ((b_q.size() != 0 || r_q.size() != 0 || busy) && n < budget) begin
            n++;
            @(negedge clk_sys);
        end
        chk("drain_q", 64'(b_q.size() + r_q.size()), 64'd0);
        chk("drain_busy", 64'(busy), 64'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog total=%0d bad=%0d", n_total, n_bad);
        $fatal(1, "watchdog");
    end

    initial begin
        req       = '0;
        req.b_ready = 1'b1;
        req.r_ready = 1'b1;
        req_s     = '0;
        cnt_clr   = 1'b0;
        cnt_clr_s = 1'b0;
        rst       = 1'b1;

        repeat (3) @(negedge clk_sys);
        chk("rst_aw_ready", 64'(rsp.aw_ready), 64'd0);
        chk("rst_ar_ready", 64'(rsp.ar_ready), 64'd0);
        chk("rst_w_ready", 64'(rsp.w_ready), 64'd0);
        chk("rst_b_valid", 64'(rsp.b_valid), 64'd0);
        chk("rst_r_valid", 64'(rsp.r_valid), 64'd0);
        chk("rst_r_data", rsp.r.data, 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_wr_cnt", 64'(wr_cnt), 64'd0);
        chk("rst_rd_cnt", 64'(rd_cnt), 64'd0);
        tick();
        rst = 1'b0;

        // single write, with W offered before AW
        req.w_valid = 1'b1;
        req.w.last  = 1'b1;
        repeat (3) begin
            @(negedge clk_sys);
            chk("w_stall", 64'(rsp.w_ready), 64'd0);
        end
        req.w_valid = 1'b0;
        req.w.last  = 1'b0;
        b_q.push_back(4'd3);
        do_aw(4'd3, 8'd0, 6'b0);
        chk("w_lat", 64'(rsp.w_ready), 64'd1);
        do_w(1'b1);
        chk("b_lat", 64'(rsp.b_valid), 64'd1);
        wait_drain(20);
        chk("wr_cnt_1", 64'(wr_cnt), 64'd1);

        // read burst len=3, back-to-back
        for (int i = 0; i < 4; i++) r_q.push_back('{id: 4'd5, last: (i == 3)});
        do_ar(4'd5, 8'd3);
        chk("ar_lat", 64'(rsp.r_valid), 64'd1);
        repeat (4) begin
            @(negedge clk_sys);
            chk("r_b2b", 64'(rsp.r_valid), 64'd1);
        end
        @(negedge clk_sys);
        chk("r_end", 64'(rsp.r_valid), 64'd0);
        wait_drain(20);
        chk("rd_cnt_1", 64'(rd_cnt), 64'd1);

        // read backpressure: r_ready 1,0,0,1
        for (int i = 0; i < 2; i++) r_q.push_back('{id: 4'd6, last: (i == 1)});
        do_ar(4'd6, 8'd1);
        tick();
        req.r_ready = 1'b0;
        tick();
        tick();
        req.r_ready = 1'b1;
        wait_drain(20);
        chk("rd_cnt_2", 64'(rd_cnt), 64'd2);

        // B held off for 3 cycles
        req.b_ready = 1'b0;
        b_q.push_back(4'd4);
        do_aw(4'd4, 8'd0, 6'b0);
        do_w(1'b1);
        repeat (3) begin
            @(negedge clk_sys);
            chk("b_hold", 64'(rsp.b_valid), 64'd1);
            chk("b_hold_id", 64'(rsp.b.id), 64'd4);
        end
        req.b_ready = 1'b1;
        wait_drain(20);
        chk("wr_cnt_2", 64'(wr_cnt), 64'd2);

        // early w.last relative to len=3
        b_q.push_back(4'd1);
        do_aw(4'd1, 8'd3, 6'b0);
        do_w(1'b1);
        wait_drain(20);
        chk("wr_cnt_early", 64'(wr_cnt), 64'd3);

        // late w.last relative to len=0
        b_q.push_back(4'd8);
        do_aw(4'd8, 8'd0, 6'b0);
        do_w(1'b0);
        chk("w_late_nob1", 64'(rsp.b_valid), 64'd0);
        do_w(1'b0);
        chk("w_late_nob2", 64'(rsp.b_valid), 64'd0);
        do_w(1'b1);
        chk("w_late_b", 64'(rsp.b_valid), 64'd1);
        wait_drain(20);
        chk("wr_cnt_late", 64'(wr_cnt), 64'd4);

        // atomic with read response
        req.b_ready = 1'b0;
        b_q.push_back(4'd7);
        r_q.push_back('{id: 4'd7, last: 1'b1});
        do_aw(4'd7, 8'd0, 6'b110000);
        do_w(1'b1);
        req.b_ready = 1'b1;
        tick();
        chk("atop_ar_block", 64'(rsp.ar_ready), 64'd0);
        chk("atop_aw_block", 64'(rsp.aw_ready), 64'd0);
        chk("atop_busy", 64'(busy), 64'd1);
        wait_drain(20);
        chk("wr_cnt_atop", 64'(wr_cnt), 64'd5);
        chk("rd_cnt_atop", 64'(rd_cnt), 64'd3);

        // concurrent AW and AR, 256-beat read
        b_q.push_back(4'd2);
        for (int i = 0; i < 256; i++) r_q.push_back('{id: 4'd9, last: (i == 255)});
        fork
            do_aw(4'd2, 8'd0, 6'b0);
            do_ar(4'd9, 8'd255);
        join
        chk("conc_r_valid", 64'(rsp.r_valid), 64'd1);
        chk("conc_w_ready", 64'(rsp.w_ready), 64'd1);
        do_w(1'b1);
        wait_drain(400);
        chk("wr_cnt_conc", 64'(wr_cnt), 64'd6);
        chk("rd_cnt_conc", 64'(rd_cnt), 64'd4);

        // clear coinciding with a read completion
        r_q.push_back('{id: 4'd10, last: 1'b1});
        do_ar(4'd10, 8'd0);
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        chk("clr_rd", 64'(rd_cnt), 64'd0);
        chk("clr_wr", 64'(wr_cnt), 64'd0);
        wait_drain(20);
        r_q.push_back('{id: 4'd11, last: 1'b1});
        do_ar(4'd11, 8'd0);
        wait_drain(20);
        chk("rd_cnt_after_clr", 64'(rd_cnt), 64'd1);

        // saturation on the 2-bit instance: many completions, count pinned at 3
        tick();
        req_s.aw_valid = 1'b1;
        req_s.w_valid  = 1'b1;
        req_s.w.last   = 1'b1;
        req_s.b_ready  = 1'b1;
        req_s.ar_valid = 1'b1;
        req_s.r_ready  = 1'b1;
        repeat (24) tick();
        req_s = '0;
        repeat (4) tick();
        chk("sat_rd", 64'(rd_cnt_s), 64'd3);
        chk("sat_wr", 64'(wr_cnt_s), 64'd3);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/iopmp_err_responder.md
Name: iopmp_err_responder

Overview:
- Terminal AXI4 responder placed behind the IOPMP deny path. Every transaction the IOPMP rejects is routed here instead of to the real slave.
- Completes each routed transaction protocol-correctly with an error response: absorbs write data, returns B, returns the full R burst.
- Keeps saturating counters of terminated bursts for the IOPMP error-reporting registers.
- Uses the shared master-side req_t/resp_t channel structs, ID width 4.

Parameters:
- req_t, lint_wrapper::req_t, AXI request struct type.
- resp_t, lint_wrapper::resp_t, AXI response struct type.
- RespCode, axi_pkg::RESP_SLVERR (2'b10), resp field driven on every B and R beat.
- RespData, 64'hBADC_AB1E_DEAD_BEEF, data driven on every R beat.
- CntWidth, 16, width of the error counters.

Ports:
- clk_i  in  1  clock; everything is on the rising edge.
- rst_i  in  1  synchronous active-high reset.
- slv_req_i  in  req_t  denied AXI request from the IOPMP demux.
- slv_rsp_o  out  resp_t  AXI response back to the demux.
- cnt_clr_i  in  1  synchronous clear of both counters.
- err_wr_cnt_o  out  CntWidth  count of completed write bursts (B handshakes).
- err_rd_cnt_o  out  CntWidth  count of completed read bursts (R handshakes with last).
- busy_o  out  1  high when either FSM is not idle or an atomic read response is pending.

Behaviour:
- Reset: while rst_i=1, every slv_rsp_o ready/valid is 0, all data fields are 0, counters are 0, busy_o=0. Both FSMs go to IDLE and atop_pend is cleared.
- Reset mid-burst abandons the burst with no further beats.
- Write FSM, states W_IDLE, W_DATA, W_RESP:
  - aw_ready = (state==W_IDLE) && !atop_pend.
  - AW handshake captures id and atop; if atop[5]=1 it also captures len into the atop slot. Next state W_DATA.
  - w_ready=1 only in W_DATA. W beats presented before AW are stalled, never accepted.
  - A W handshake with last=1 moves to W_RESP.
  - In W_RESP, b_valid=1 with b.id=captured id, b.resp=RespCode, b.user=0.
  - B handshake returns to W_IDLE and increments err_wr_cnt.
  - If atop[5] was captured, atop_pend is set in the same cycle as the B handshake.
- Read FSM, states R_IDLE, R_DATA:
  - ar_ready = (state==R_IDLE) && !atop_pend.
  - In R_IDLE with atop_pend=1, it loads the atop id/len, clears atop_pend and enters R_DATA. This takes priority over AR.
  - Otherwise an AR handshake loads ar.id and ar.len into an 8-bit beat counter and enters R_DATA.
  - In R_DATA, r_valid=1 with r.id=captured id, r.data=RespData, r.resp=RespCode, r.user=0, and r.last=(beat counter==0).
  - Each R handshake decrements the counter. The handshake with last returns to R_IDLE and increments err_rd_cnt.
- Latency:
  - AW handshake at cycle T gives w_ready at T+1.
  - Last W handshake at T gives b_valid at T+1.
  - AR handshake at T gives first r_valid at T+1.
  - R beats go back-to-back while r_ready is held, so a burst of len+1 beats needs len+1 cycles of r_ready.
- Stall: r_valid and b_valid stay asserted with stable payload until the handshake (AXI rule). The beat counter is unchanged when r_ready=0.
- Boundaries:
  - len=0 gives one beat with last=1.
  - len=255 gives 256 beats; the counter must not wrap before last.
  - A W last flag arriving early or late relative to AW.len is ignored; only w.last ends the write data phase.
- Independence: the write and read FSMs run concurrently. Simultaneous AW and AR handshakes in the same cycle are both accepted.
- Counters:
  - Saturate at all-ones.
  - cnt_clr_i has priority over an increment in the same cycle; the result is 0.

Decomposition:
- New package iopmp_err_pkg: w_state_e, r_state_e, default RespData constant, atop_slot_t struct {id_t id; axi_pkg::len_t len}. It imports the shared lint_wrapper id_t.
- Sub-module iopmp_err_rd_chan: read FSM, beat counter, atop-slot consumption and R-side counter.
- The write FSM stays inline in the top.

Test Plan:
1. Reset then single write: AW id=3 len=0, then one W with last=1 → w_ready at T+1, b_valid next cycle with id=3, resp=2'b10; err_wr_cnt=1.
2. Read burst: AR id=5 len=3, r_ready held 1 → four R beats on consecutive cycles, data=RespData, last only on beat 4; err_rd_cnt=1.
3. Backpressure: AR len=1, r_ready toggled 1,0,0,1 → beat 1 payload stable during the stall; exactly 2 beats total; B similarly held 3 cycles with b_ready=0.
4. Atomic: AW id=7 atop=6'b110000 len=0 → B id=7, then one R beat id=7 last=1; ar_ready=0 while atop_pend=1.
5. Concurrency/boundaries: AW and AR handshake in the same cycle (AR len=255) → 256 R beats interleaved with the write completing; err_rd_cnt and err_wr_cnt each +1.
6. Counter saturation and clear: with the counter forced to 16'hFFFF it stays at 16'hFFFF after another completion; cnt_clr_i asserted in the same cycle as a completion → 0.
